// File: rtl/boot_loader_ctrl_if.sv
// -----------------------------------------------------------------------------
// boot_loader_ctrl_if
//
// Bundles the two handshakes of the boot loader:
//   - byte stream from the UART/SPI receiver (rx_data, rx_valid, rx_ready)
//   - instruction RAM boot port (boot_req, boot_we, boot_be, boot_addr,
//     boot_wdata, boot_gnt)
//
// Modports:
//   master : the boot loader controller (consumes bytes, drives the RAM port)
//   slave  : the environment (byte source and RAM)
// -----------------------------------------------------------------------------
interface boot_loader_ctrl_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  logic        boot_req;
  logic        boot_we;
  logic [3:0]  boot_be;
  logic [31:0] boot_addr;
  logic [31:0] boot_wdata;
  logic        boot_gnt;

  modport master (
    input  rx_data, rx_valid, boot_gnt,
    output rx_ready, boot_req, boot_we, boot_be, boot_addr, boot_wdata
  );

  modport slave (
    output rx_data, rx_valid, boot_gnt,
    input  rx_ready, boot_req, boot_we, boot_be, boot_addr, boot_wdata
  );

endinterface

// File: rtl/boot_loader_ctrl.sv
// -----------------------------------------------------------------------------
// boot_loader_ctrl
//
// Boot sequencer for the instruction RAM boot port. Out of reset it holds the
// CPU in reset and owns the RAM primary port (rst_boot=1). It receives a framed
// program image as a byte stream:
//
//   SYNC_BYTE, N[7:0], N[15:8], N*4 data bytes (little-endian words)
//   [, checksum byte when BOOT_CSUM_EN is defined]
//
// and writes each assembled word to consecutive RAM word addresses. On success
// it releases the RAM port and, two cycles later, the CPU.
//
// Optional feature (compile-time macro): BOOT_CSUM_EN
//   defined   : a trailing checksum byte (sum mod 256 of all data bytes) is
//               checked; a mismatch ends in ERR with code 3.
//   undefined : no checksum state/accumulator; the last write goes to DONE.
//
// Parameters:
//   Depth       RAM size in words; maximum image length N
//   SYNC_BYTE   frame start marker
//   TIMEOUT_CYC inter-byte timeout in clk cycles (>= 2)
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        pulse; restarts boot from DONE or ERR, ignored elsewhere
//   bus          byte stream + RAM boot port (boot_loader_ctrl_if.master)
//   rst_boot     1 = RAM port owned by the boot side
//   cpu_rst_n    CPU reset, active-low
//   done         image loaded
//   err          load failed
//   err_code     0 none, 1 bad length, 2 timeout, 3 checksum
// -----------------------------------------------------------------------------
module boot_loader_ctrl #(
  parameter int unsigned Depth       = 128,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  boot_loader_ctrl_if.master        bus,
  output logic                      rst_boot,
  output logic                      cpu_rst_n,
  output logic                      done,
  output logic                      err,
  output logic [1:0]                err_code
);

  localparam int unsigned       IDX_W    = $clog2(Depth + 1);
  localparam int unsigned       TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [15:0]       DEPTH_W  = 16'(Depth);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
`ifdef BOOT_CSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_TMO  = 2'd2,
    ERR_CSUM = 2'd3
  } err_e;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               settle_q, settle_d;
`ifdef BOOT_CSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  logic               boot_req_q, boot_req_d;
  logic               boot_we_q, boot_we_d;
  logic [3:0]         boot_be_q, boot_be_d;
  logic [31:0]        boot_addr_q, boot_addr_d;
  logic [31:0]        boot_wdata_q, boot_wdata_d;
  logic               rst_boot_q, rst_boot_d;
  logic               cpu_rst_n_q, cpu_rst_n_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;

  // ---------------------------------------------------------------------------
  // Decodes
  // ---------------------------------------------------------------------------
  logic        timed;      // states where the inter-byte timeout runs
  logic        rx_ready_w;
  logic        rx_fire;
  logic [15:0] len_n;      // word count as it completes in LEN1
  logic        last_word;

  assign timed = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA)
`ifdef BOOT_CSUM_EN
              || (state_q == S_CSUM)
`endif
              ;

  assign rx_ready_w = (state_q == S_SYNC) || timed;
  assign rx_fire    = bus.rx_valid && rx_ready_w;
  assign len_n      = {bus.rx_data, len_q[7:0]};
  assign last_word  = (16'(word_idx_q) == (len_q - 16'd1));

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  logic enter_done;
  logic enter_err;
  err_e err_sel;
  logic restart;

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    tmo_d        = '0;
    settle_d     = settle_q;
`ifdef BOOT_CSUM_EN
    csum_d       = csum_q;
`endif
    boot_req_d   = boot_req_q;
    boot_we_d    = boot_we_q;
    boot_be_d    = boot_be_q;
    boot_addr_d  = boot_addr_q;
    boot_wdata_d = boot_wdata_q;
    rst_boot_d   = rst_boot_q;
    cpu_rst_n_d  = cpu_rst_n_q;
    done_d       = done_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    enter_done   = 1'b0;
    enter_err    = 1'b0;
    err_sel      = ERR_NONE;
    restart      = 1'b0;

    // Counter restarts on every accepted byte and on every state entry
    // (tmo_d defaults to zero); it only advances while idling in a timed state.
    if (timed && !rx_fire) begin
      if (tmo_q == TMO_LAST) begin
        enter_err = 1'b1;
        err_sel   = ERR_TMO;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    case (state_q)
      S_SYNC: begin
        if (rx_fire && (bus.rx_data == SYNC_BYTE)) state_d = S_LEN0;
      end

      S_LEN0: begin
        if (rx_fire) begin
          len_d[7:0] = bus.rx_data;
          state_d    = S_LEN1;
        end
      end

      S_LEN1: begin
        if (rx_fire) begin
          len_d = len_n;
          if ((len_n == 16'd0) || (len_n > DEPTH_W)) begin
            enter_err = 1'b1;
            err_sel   = ERR_LEN;
          end else begin
            state_d    = S_DATA;
            word_idx_d = '0;
            byte_idx_d = '0;
`ifdef BOOT_CSUM_EN
            csum_d     = '0;
`endif
          end
        end
      end

      S_DATA: begin
        if (rx_fire) begin
          boot_wdata_d[{byte_idx_q, 3'b000} +: 8] = bus.rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef BOOT_CSUM_EN
          csum_d     = csum_q + bus.rx_data;
`endif
          if (byte_idx_q == 2'd3) begin
            state_d     = S_WRITE;
            boot_req_d  = 1'b1;
            boot_we_d   = 1'b1;
            boot_be_d   = 4'hF;
            boot_addr_d = 32'(word_idx_q) << 2;
          end
        end
      end

      // Request, address and data stay put until the RAM grants; the grant is
      // a registered echo of the request, so at least one wait cycle occurs.
      S_WRITE: begin
        if (bus.boot_gnt) begin
          boot_req_d = 1'b0;
          boot_we_d  = 1'b0;
          if (last_word) begin
`ifdef BOOT_CSUM_EN
            state_d    = S_CSUM;
`else
            enter_done = 1'b1;
`endif
          end else begin
            word_idx_d = word_idx_q + IDX_W'(1);
            state_d    = S_DATA;
          end
        end
      end

`ifdef BOOT_CSUM_EN
      S_CSUM: begin
        if (rx_fire) begin
          if (bus.rx_data == csum_q) begin
            enter_done = 1'b1;
          end else begin
            enter_err = 1'b1;
            err_sel   = ERR_CSUM;
          end
        end
      end
`endif

      // The CPU leaves reset two cycles after the port mux switches away from
      // the boot side, so the RAM path has settled before the first fetch.
      S_DONE: begin
        if (start) begin
          restart = 1'b1;
        end else begin
          if (settle_q) cpu_rst_n_d = 1'b1;
          settle_d = 1'b1;
        end
      end

      S_ERR: begin
        if (start) restart = 1'b1;
      end

      default: state_d = S_SYNC;
    endcase

    if (enter_done) begin
      state_d    = S_DONE;
      done_d     = 1'b1;
      rst_boot_d = 1'b0;
      settle_d   = 1'b0;
    end

    if (enter_err) begin
      state_d    = S_ERR;
      err_d      = 1'b1;
      err_code_d = err_sel;
    end

    if (restart) begin
      state_d     = S_SYNC;
      rst_boot_d  = 1'b1;
      cpu_rst_n_d = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      err_code_d  = ERR_NONE;
      len_d       = '0;
      word_idx_d  = '0;
      byte_idx_d  = '0;
      settle_d    = 1'b0;
`ifdef BOOT_CSUM_EN
      csum_d      = '0;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_SYNC;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      tmo_q        <= '0;
      settle_q     <= 1'b0;
`ifdef BOOT_CSUM_EN
      csum_q       <= '0;
`endif
      boot_req_q   <= 1'b0;
      boot_we_q    <= 1'b0;
      boot_be_q    <= '0;
      boot_addr_q  <= '0;
      boot_wdata_q <= '0;
      rst_boot_q   <= 1'b1;
      cpu_rst_n_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      tmo_q        <= tmo_d;
      settle_q     <= settle_d;
`ifdef BOOT_CSUM_EN
      csum_q       <= csum_d;
`endif
      boot_req_q   <= boot_req_d;
      boot_we_q    <= boot_we_d;
      boot_be_q    <= boot_be_d;
      boot_addr_q  <= boot_addr_d;
      boot_wdata_q <= boot_wdata_d;
      rst_boot_q   <= rst_boot_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.rx_ready   = rx_ready_w;
  assign bus.boot_req   = boot_req_q;
  assign bus.boot_we    = boot_we_q;
  assign bus.boot_be    = boot_be_q;
  assign bus.boot_addr  = boot_addr_q;
  assign bus.boot_wdata = boot_wdata_q;
  assign rst_boot       = rst_boot_q;
  assign cpu_rst_n      = cpu_rst_n_q;
  assign done           = done_q;
  assign err            = err_q;
  assign err_code       = err_code_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// -----------------------------------------------------------------------------
// tb_boot_loader_ctrl
//
// Directed bench for boot_loader_ctrl. A small RAM model returns boot_gnt as a
// registered echo of boot_req (optionally after extra wait cycles) and logs
// every granted write. Outputs are sampled on the falling clock edge.
// With BOOT_CSUM_EN defined, frames carry the checksum byte 0x64
// (0x11+0x22+...+0x88 mod 256) and a bad-checksum case is added.
// -----------------------------------------------------------------------------
module tb_boot_loader_ctrl;

  localparam int unsigned TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       rst_boot;
  logic       cpu_rst_n;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  boot_loader_ctrl_if bus ();

  boot_loader_ctrl #(
    .Depth       (128),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .rst_boot  (rst_boot),
    .cpu_rst_n (cpu_rst_n),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // RAM model: grant is a registered copy of req, delayed by gnt_delay extra
  // cycles; a write is logged at the edge where req, we and gnt are all high.
  // ---------------------------------------------------------------------------
  int          gnt_delay = 0;
  int          req_cnt   = 0;
  int          wr_cnt    = 0;
  logic [31:0] log_addr [0:31];
  logic [31:0] log_data [0:31];
  logic [3:0]  log_be   [0:31];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.boot_gnt <= 1'b0;
      req_cnt      <= 0;
    end else if (bus.boot_req) begin
      bus.boot_gnt <= (req_cnt >= gnt_delay);
      req_cnt      <= req_cnt + 1;
      if (bus.boot_we && bus.boot_gnt && wr_cnt < 32) begin
        log_addr[wr_cnt] <= bus.boot_addr;
        log_data[wr_cnt] <= bus.boot_wdata;
        log_be[wr_cnt]   <= bus.boot_be;
        wr_cnt           <= wr_cnt + 1;
      end
    end else begin
      bus.boot_gnt <= 1'b0;
      req_cnt      <= 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Request monitor (falling edge): length of the last request burst, number
  // of request bursts, rx_ready seen high during a request, and address/data
  // changes while a request is held.
  // ---------------------------------------------------------------------------
  int          run       = 0;
  int          last_run  = 0;
  int          req_rises = 0;
  int          rdy_viol  = 0;
  int          unstable  = 0;
  logic        prev_req  = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (bus.boot_req) begin
      run <= run + 1;
      if (!prev_req) req_rises <= req_rises + 1;
      if (bus.rx_ready) rdy_viol <= rdy_viol + 1;
      if (prev_req && (bus.boot_addr != prev_addr || bus.boot_wdata != prev_data))
        unstable <= unstable + 1;
    end else if (prev_req) begin
      last_run <= run;
      run      <= 0;
    end
    prev_req  <= bus.boot_req;
    prev_addr <= bus.boot_addr;
    prev_data <= bus.boot_wdata;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame();
    logic [7:0] fr [0:10];
    fr = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
           8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 11; i++) send_byte(fr[i]);
  endtask

  task automatic send_good_frame();
    send_frame();
`ifdef BOOT_CSUM_EN
    send_byte(8'h64);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Polls on falling edges (starting with the next one) until done/err is set.
  task automatic wait_flag(input bit want_err, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((want_err ? err : done) !== 1'b1) && n < 300);
    check(tag, 32'(want_err ? err : done), 32'd1);
  endtask

  // Two writes of the reference frame starting at log index base.
  task automatic check_frame_writes(input int base, input string pfx);
    check({pfx, "_wr_cnt"}, 32'(wr_cnt - base), 32'd2);
    check({pfx, "_addr0"},  log_addr[base],     32'h0000_0000);
    check({pfx, "_data0"},  log_data[base],     32'h4433_2211);
    check({pfx, "_addr1"},  log_addr[base + 1], 32'h0000_0004);
    check({pfx, "_data1"},  log_data[base + 1], 32'h8877_6655);
    check({pfx, "_be1"},    32'(log_be[base + 1]), 32'hF);
  endtask

  // Completion: flags plus the two-cycle CPU release delay.
  task automatic check_done_seq(input string pfx);
    wait_flag(1'b0, {pfx, "_done"});
    check({pfx, "_rst_boot"}, 32'(rst_boot),  32'd0);
    check({pfx, "_err"},      32'(err),       32'd0);
    check({pfx, "_cpu_e0"},   32'(cpu_rst_n), 32'd0);
    @(negedge clk);
    check({pfx, "_cpu_e1"},   32'(cpu_rst_n), 32'd0);
    @(negedge clk);
    check({pfx, "_cpu_e2"},   32'(cpu_rst_n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int base;
    int rises;

    rst_n        = 1'b0;
    start        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_rst_boot",  32'(rst_boot),       32'd1);
    check("rst_cpu_rst_n", 32'(cpu_rst_n),      32'd0);
    check("rst_req",       32'(bus.boot_req),   32'd0);
    check("rst_we",        32'(bus.boot_we),    32'd0);
    check("rst_be",        32'(bus.boot_be),    32'd0);
    check("rst_addr",      bus.boot_addr,       32'd0);
    check("rst_wdata",     bus.boot_wdata,      32'd0);
    check("rst_done",      32'(done),           32'd0);
    check("rst_err",       32'(err),            32'd0);
    check("rst_err_code",  32'(err_code),       32'd0);
    check("rst_rx_ready",  32'(bus.rx_ready),   32'd1);

    // 1: reference frame
    base = wr_cnt;
    send_good_frame();
    check_done_seq("t1");
    check_frame_writes(base, "t1");
    check("t1_req_len", 32'(last_run), 32'd2);
    check("t1_rx_ready_done", 32'(bus.rx_ready), 32'd0);

    // 2: leading junk bytes are discarded
    pulse_start();
    check("t2_restart_done",  32'(done),      32'd0);
    check("t2_restart_boot",  32'(rst_boot),  32'd1);
    check("t2_restart_cpu",   32'(cpu_rst_n), 32'd0);
    base = wr_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    send_good_frame();
    check_done_seq("t2");
    check_frame_writes(base, "t2");

    // 3: zero length, then 129 > Depth
    pulse_start();
    base = wr_cnt;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_flag(1'b1, "t3a_err");
    check("t3a_code",     32'(err_code),       32'd1);
    check("t3a_no_write", 32'(wr_cnt - base),  32'd0);
    check("t3a_rst_boot", 32'(rst_boot),       32'd1);
    check("t3a_cpu",      32'(cpu_rst_n),      32'd0);
    pulse_start();
    check("t3_clr_err",  32'(err),      32'd0);
    check("t3_clr_code", 32'(err_code), 32'd0);
    send_byte(8'hA5);
    send_byte(8'h81);
    send_byte(8'h00);
    wait_flag(1'b1, "t3b_err");
    check("t3b_code",     32'(err_code),      32'd1);
    check("t3b_no_write", 32'(wr_cnt - base), 32'd0);

    // 4: length 128 (= Depth) accepted, then timeout after two data bytes
    pulse_start();
    rises = req_rises;
    send_byte(8'hA5);
    send_byte(8'h80);
    send_byte(8'h00);
    check("t4_len128_ok", 32'(err), 32'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TMO) @(negedge clk);
    check("t4_not_yet_err",  32'(err),          32'd0);
    check("t4_still_ready",  32'(bus.rx_ready), 32'd1);
    @(negedge clk);
    check("t4_err",          32'(err),          32'd1);
    check("t4_code",         32'(err_code),     32'd2);
    check("t4_no_req",       32'(req_rises - rises), 32'd0);
    check("t4_rst_boot",     32'(rst_boot),     32'd1);
    check("t4_cpu",          32'(cpu_rst_n),    32'd0);

    // 5: grant delayed 3 extra cycles; request held 5 cycles per word
    gnt_delay = 3;
    pulse_start();
    base  = wr_cnt;
    rises = req_rises;
    send_good_frame();
    check_done_seq("t5");
    check_frame_writes(base, "t5");
    check("t5_req_len",   32'(last_run),          32'd5);
    check("t5_req_count", 32'(req_rises - rises), 32'd2);
    check("t5_rdy_viol",  32'(rdy_viol),          32'd0);
    check("t5_unstable",  32'(unstable),          32'd0);
    gnt_delay = 0;

`ifdef BOOT_CSUM_EN
    // 6: bad checksum, then good checksum
    pulse_start();
    send_frame();
    send_byte(8'h65);
    wait_flag(1'b1, "t6_err");
    check("t6_code",     32'(err_code),  32'd3);
    check("t6_cpu",      32'(cpu_rst_n), 32'd0);
    check("t6_rst_boot", 32'(rst_boot),  32'd1);
    pulse_start();
    send_frame();
    send_byte(8'h64);
    check_done_seq("t6b");
`endif

    // start mid-load is ignored; asynchronous reset mid-load
    pulse_start();
    base  = wr_cnt;
    rises = req_rises;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    pulse_start();
    send_byte(8'h33);
    send_byte(8'h44);
    repeat (4) @(negedge clk);
    check("mid_one_req",   32'(req_rises - rises), 32'd1);
    check("mid_one_write", 32'(wr_cnt - base),     32'd1);
    check("mid_wr_data",   log_data[base],         32'h4433_2211);
    send_byte(8'h55);
    send_byte(8'h66);
    check("mid_pre_rst_wdata", bus.boot_wdata, 32'h4433_6655);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wdata",    bus.boot_wdata,    32'd0);
    check("mid_rst_rst_boot", 32'(rst_boot),     32'd1);
    check("mid_rst_cpu",      32'(cpu_rst_n),    32'd0);
    check("mid_rst_req",      32'(bus.boot_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.rx_ready), 32'd1);
    check("post_rst_done",  32'(done),         32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
